// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit.
// LWL/LWR decode legality depends on the LSU_LWLR_EN define.
package mips_cpu_lsu_pkg;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        SB  = 4'd5,
        SH  = 4'd6,
        SW  = 4'd7,
        LWL = 4'd8,
        LWR = 4'd9
    } lsu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP,
        ERR
    } lsu_state_t;

    function automatic logic op_legal(input logic [3:0] op);
`ifdef LSU_LWLR_EN
        return (op <= 4'd9);
`else
        return (op <= 4'd7);
`endif
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            LW, SW:       return (lo != 2'b00);
            LH, LHU, SH:  return lo[0];
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_rmw(input logic [3:0] op);
        return (op == SB) || (op == SH);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Combinational lane logic: load extract/extend, SB/SH store merge and the
// LWL/LWR register merge (only reachable when LSU_LWLR_EN admits those ops).
module mips_cpu_lsu_align
    import mips_cpu_lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] merge_buf_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rt_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [4:0]  left_sh;
    logic [31:0] byte_word;
    logic [31:0] half_word;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    always_comb begin
        byte_sh   = {lane_i, 3'b000};
        half_sh   = {lane_i[1], 4'b0000};
        // 8*(3-b) is the bitwise complement of b scaled by 8
        left_sh   = {~lane_i, 3'b000};
        byte_word = rdata_i >> byte_sh;
        half_word = rdata_i >> half_sh;
        byte_mask = 32'h0000_00FF << byte_sh;
        half_mask = 32'h0000_FFFF << half_sh;

        load_data_o = '0;
        case (op_i)
            LB:      load_data_o = {{24{byte_word[7]}}, byte_word[7:0]};
            LBU:     load_data_o = {24'h0, byte_word[7:0]};
            LH:      load_data_o = {{16{half_word[15]}}, half_word[15:0]};
            LHU:     load_data_o = {16'h0, half_word[15:0]};
            LW:      load_data_o = rdata_i;
            LWL:     load_data_o = (rdata_i << left_sh) | (rt_i & ~(32'hFFFF_FFFF << left_sh));
            LWR:     load_data_o = (rdata_i >> byte_sh) | (rt_i & ~(32'hFFFF_FFFF >> byte_sh));
            default: load_data_o = '0;
        endcase

        store_data_o = merge_buf_i;
        case (op_i)
            SB:      store_data_o = (merge_buf_i & ~byte_mask) | ({24'h0, wdata_i[7:0]} << byte_sh);
            SH:      store_data_o = (merge_buf_i & ~half_mask) | ({16'h0, wdata_i[15:0]} << half_sh);
            SW:      store_data_o = wdata_i;
            default: store_data_o = merge_buf_i;
        endcase
    end

endmodule

// File: rtl/mips_cpu_load_store_unit.sv
// Load/store unit between the MEM stage and mips_cpu_dMemory; SB/SH use
// read-modify-write. Define LSU_LWLR_EN to enable the LWL/LWR ops.
module mips_cpu_load_store_unit
    import mips_cpu_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter bit          ERR_ON_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_rt,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata
);

    lsu_state_t        state_q, state_d;
    lsu_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rt_q, rt_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       load_data;
    logic [31:0]       store_data;

    // With ERR_ON_MISALIGN=0 the raw address is kept: halfword lanes only use
    // addr[1] and words ignore addr[1:0], which aligns down implicitly.
    mips_cpu_lsu_align u_align (
        .op_i        (op_q),
        .lane_i      (addr_q[1:0]),
        .rdata_i     (mem_readdata),
        .merge_buf_i (buf_q),
        .wdata_i     (wdata_q),
        .rt_i        (rt_q),
        .load_data_o (load_data),
        .store_data_o(store_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= LB;
            addr_q  <= '0;
            wdata_q <= '0;
            rt_q    <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rt_q    <= rt_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rt_d    = rt_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = lsu_op_t'(req_op);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rt_d    = req_rt;
                    rdata_d = '0;
                    if (!op_legal(req_op) ||
                        (ERR_ON_MISALIGN && op_misaligned(req_op, req_addr[1:0])))
                        state_d = ERR;
                    else
                        state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (op_is_rmw(op_q)) begin
                    buf_d   = mem_readdata;
                    state_d = WRITE;
                end else begin
                    rdata_d = op_is_store(op_q) ? '0 : load_data;
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state_q == IDLE);
        resp_valid    = (state_q == RESP) || (state_q == ERR);
        resp_err      = (state_q == ERR);
        resp_rdata    = (state_q == RESP) ? rdata_q : '0;
        mem_read      = (state_q == ACCESS);
        mem_write     = ((state_q == ACCESS) && (op_q == SW)) || (state_q == WRITE);
        mem_address   = '0;
        mem_writedata = '0;
        if ((state_q == ACCESS) || (state_q == WRITE))
            mem_address = {addr_q[ADDR_W-1:2], 2'b00};
        if (mem_write)
            mem_writedata = store_data;
    end

endmodule

// File: tb/tb_mips_cpu_load_store_unit.sv
// Self-checking bench for mips_cpu_load_store_unit with a byte-array memory model.
// Honours LSU_LWLR_EN in the same way as the design.
module tb_mips_cpu_load_store_unit;
    import mips_cpu_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic [31:0] dmem [0:63];
    logic [7:0]  refm [0:255];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign mem_readdata = dmem[mem_address[7:2]];
    always @(posedge clk) if (mem_write) dmem[mem_address[7:2]] <= mem_writedata;

    mips_cpu_load_store_unit #(.ADDR_W(32), .ERR_ON_MISALIGN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rt       (req_rt),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata)
    );

    function automatic logic [31:0] ref_word(input int a);
        return {refm[a+3], refm[a+2], refm[a+1], refm[a]};
    endfunction

    // Reference behaviour in byte terms; updates refm for stores.
    function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rt,
                                  output logic [31:0] rd, output logic er, output int lat);
        int a;
        int b;
        int wb;
        logic ill;
        logic mis;
        a  = int'(addr[7:0]);
        b  = int'(addr[1:0]);
        wb = a - b;
`ifdef LSU_LWLR_EN
        ill = (op > 4'd9);
`else
        ill = (op > 4'd7);
`endif
        mis = ((op == 4'd4 || op == 4'd7) && b != 0) ||
              ((op == 4'd2 || op == 4'd3 || op == 4'd6) && addr[0]);
        rd  = '0;
        er  = 1'b0;
        lat = 2;
        if (ill || mis) begin
            er  = 1'b1;
            lat = 1;
            return;
        end
        case (op)
            4'd0: rd = {{24{refm[a][7]}}, refm[a]};
            4'd1: rd = {24'h0, refm[a]};
            4'd2: rd = {{16{refm[a+1][7]}}, refm[a+1], refm[a]};
            4'd3: rd = {16'h0, refm[a+1], refm[a]};
            4'd4: rd = ref_word(a);
            4'd5: begin refm[a] = wd[7:0]; lat = 3; end
            4'd6: begin refm[a] = wd[7:0]; refm[a+1] = wd[15:8]; lat = 3; end
            4'd7: begin
                refm[a] = wd[7:0]; refm[a+1] = wd[15:8];
                refm[a+2] = wd[23:16]; refm[a+3] = wd[31:24];
            end
            4'd8: for (int k = 0; k < 4; k++)
                rd[8*k +: 8] = (k >= 3 - b) ? refm[wb + k - (3 - b)] : rt[8*k +: 8];
            4'd9: for (int k = 0; k < 4; k++)
                rd[8*k +: 8] = (k <= 3 - b) ? refm[wb + k + b] : rt[8*k +: 8];
            default: rd = '0;
        endcase
    endfunction

    // Issues one request, keeps req_valid high with junk while busy, and
    // waits (bounded) for the response pulse.
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rt,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic ready, output logic touched);
        @(negedge clk);
        ready     = req_ready;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_rt    = rt;
        @(posedge clk);
        #1;
        req_op    = 4'($urandom_range(0, 15));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rt    = $urandom;
        touched   = 1'b0;
        lat       = -1;
        rd        = 'x;
        er        = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_read || mem_write) touched = 1'b1;
            if (resp_valid) begin
                lat = i;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        tests_run++;
        if ({resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_address, mem_writedata, req_ready}
            !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_outputs: rv=%b re=%b rd=%h mr=%b mw=%b ma=%h mwd=%h rdy=%b expected all 0, rdy=1",
                     resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_address, mem_writedata, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word;
        logic [31:0] rd, erd; logic er, eer, rdy, tch; int lat, elat;
        model(4'd7, 32'h10, 32'hDEADBEEF, 32'h0, erd, eer, elat);
        do_req(4'd7, 32'h10, 32'hDEADBEEF, 32'h0, rd, er, lat, rdy, tch);
        tests_run++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != 2 || dmem[4] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL sw_0x10: rd=%h err=%b lat=%0d word=%h expected rd=0 err=0 lat=2 word=deadbeef", rd, er, lat, dmem[4]);
        end
        model(4'd4, 32'h10, 32'h0, 32'h0, erd, eer, elat);
        do_req(4'd4, 32'h10, 32'h0, 32'h0, rd, er, lat, rdy, tch);
        tests_run++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL lw_0x10: rd=%h err=%b lat=%0d expected rd=deadbeef err=0 lat=2", rd, er, lat);
        end
    endtask

    task automatic test_byte;
        logic [31:0] rd, erd; logic er, eer, rdy, tch; int lat, elat;
        model(4'd5, 32'h11, 32'h000000AB, 32'h0, erd, eer, elat);
        do_req(4'd5, 32'h11, 32'h000000AB, 32'h0, rd, er, lat, rdy, tch);
        tests_run++;
        if (dmem[4] !== 32'hDEADABEF || er !== 1'b0 || lat != 3) begin
            tests_failed++;
            $display("FAIL sb_0x11: word=%h err=%b lat=%0d expected word=deadabef err=0 lat=3", dmem[4], er, lat);
        end
        model(4'd0, 32'h11, 32'h0, 32'h0, erd, eer, elat);
        do_req(4'd0, 32'h11, 32'h0, 32'h0, rd, er, lat, rdy, tch);
        tests_run++;
        if (rd !== 32'hFFFFFFAB || er !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL lb_0x11: rd=%h err=%b lat=%0d expected rd=ffffffab err=0 lat=2", rd, er, lat);
        end
        model(4'd1, 32'h11, 32'h0, 32'h0, erd, eer, elat);
        do_req(4'd1, 32'h11, 32'h0, 32'h0, rd, er, lat, rdy, tch);
        tests_run++;
        if (rd !== 32'h000000AB || er !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL lbu_0x11: rd=%h err=%b lat=%0d expected rd=000000ab err=0 lat=2", rd, er, lat);
        end
    endtask

    task automatic test_half;
        logic [31:0] rd, erd; logic er, eer, rdy, tch; int lat, elat;
        model(4'd6, 32'h12, 32'hFFFF1234, 32'h0, erd, eer, elat);
        do_req(4'd6, 32'h12, 32'hFFFF1234, 32'h0, rd, er, lat, rdy, tch);
        tests_run++;
        if (dmem[4] !== 32'h1234ABEF || er !== 1'b0 || lat != 3) begin
            tests_failed++;
            $display("FAIL sh_0x12: word=%h err=%b lat=%0d expected word=1234abef err=0 lat=3", dmem[4], er, lat);
        end
        model(4'd6, 32'h14, 32'h00008001, 32'h0, erd, eer, elat);
        do_req(4'd6, 32'h14, 32'h00008001, 32'h0, rd, er, lat, rdy, tch);
        model(4'd2, 32'h14, 32'h0, 32'h0, erd, eer, elat);
        do_req(4'd2, 32'h14, 32'h0, 32'h0, rd, er, lat, rdy, tch);
        tests_run++;
        if (rd !== 32'hFFFF8001 || er !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL lh_0x14: rd=%h err=%b lat=%0d expected rd=ffff8001 err=0 lat=2", rd, er, lat);
        end
        do_req(4'd3, 32'h14, 32'h0, 32'h0, rd, er, lat, rdy, tch);
        tests_run++;
        if (rd !== 32'h00008001 || er !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL lhu_0x14: rd=%h err=%b lat=%0d expected rd=00008001 err=0 lat=2", rd, er, lat);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er, rdy, tch; int lat;
        logic [3:0] ops [0:3];
        logic [31:0] adrs [0:3];
        ops[0] = 4'd4; adrs[0] = 32'h13;
        ops[1] = 4'd2; adrs[1] = 32'h11;
        ops[2] = 4'd7; adrs[2] = 32'h12;
        ops[3] = 4'd6; adrs[3] = 32'h15;
        for (int i = 0; i < 4; i++) begin
            do_req(ops[i], adrs[i], 32'hFFFFFFFF, 32'h0, rd, er, lat, rdy, tch);
            tests_run++;
            if (rd !== 32'h0 || er !== 1'b1 || lat != 1 || tch !== 1'b0) begin
                tests_failed++;
                $display("FAIL misalign_op%0d_%h: rd=%h err=%b lat=%0d mem_touched=%b expected rd=0 err=1 lat=1 mem_touched=0",
                         ops[i], adrs[i], rd, er, lat, tch);
            end
        end
        for (int op = 10; op < 16; op++) begin
            do_req(4'(op), 32'h20, 32'h0, 32'h0, rd, er, lat, rdy, tch);
            tests_run++;
            if (rd !== 32'h0 || er !== 1'b1 || lat != 1 || tch !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_op%0d: rd=%h err=%b lat=%0d mem_touched=%b expected rd=0 err=1 lat=1 mem_touched=0",
                         op, rd, er, lat, tch);
            end
        end
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd5;
        req_addr  = 32'h10;
        req_wdata = 32'h00000055;
        req_rt    = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (mem_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmw_write_phase: mem_write=%b expected 1", mem_write);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (mem_write !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset_drop: mem_write=%b req_ready=%b expected 0 and 1", mem_write, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dmem[4] !== 32'h1234ABEF || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_sb: word=%h req_ready=%b expected word=1234abef req_ready=1", dmem[4], req_ready);
        end
    endtask

    task automatic test_lwlr;
        logic [31:0] rd; logic er, rdy, tch; int lat;
`ifdef LSU_LWLR_EN
        do_req(4'd8, 32'h11, 32'h0, 32'h11223344, rd, er, lat, rdy, tch);
        tests_run++;
        if (rd !== 32'hABEF3344 || er !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL lwl_0x11: rd=%h err=%b lat=%0d expected rd=abef3344 err=0 lat=2", rd, er, lat);
        end
        do_req(4'd9, 32'h11, 32'h0, 32'h11223344, rd, er, lat, rdy, tch);
        tests_run++;
        if (rd !== 32'h111234AB || er !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL lwr_0x11: rd=%h err=%b lat=%0d expected rd=111234ab err=0 lat=2", rd, er, lat);
        end
`else
        do_req(4'd8, 32'h11, 32'h0, 32'h11223344, rd, er, lat, rdy, tch);
        tests_run++;
        if (rd !== 32'h0 || er !== 1'b1 || lat != 1 || tch !== 1'b0) begin
            tests_failed++;
            $display("FAIL lwl_disabled: rd=%h err=%b lat=%0d mem_touched=%b expected rd=0 err=1 lat=1 mem_touched=0",
                     rd, er, lat, tch);
        end
        do_req(4'd9, 32'h11, 32'h0, 32'h11223344, rd, er, lat, rdy, tch);
        tests_run++;
        if (rd !== 32'h0 || er !== 1'b1 || lat != 1) begin
            tests_failed++;
            $display("FAIL lwr_disabled: rd=%h err=%b lat=%0d expected rd=0 err=1 lat=1", rd, er, lat);
        end
`endif
    endtask

    task automatic test_back_to_back_random;
        logic [31:0] rd, erd, addr, wd, rt; logic er, eer, rdy, tch; int lat, elat;
        logic [3:0] op;
        for (int n = 0; n < 150; n++) begin
            op   = 4'($urandom_range(0, 11));
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (op == 4'd4 || op == 4'd7) addr[1:0] = 2'b00;
                if (op == 4'd2 || op == 4'd3 || op == 4'd6) addr[0] = 1'b0;
            end
            wd = $urandom;
            rt = $urandom;
            model(op, addr, wd, rt, erd, eer, elat);
            do_req(op, addr, wd, rt, rd, er, lat, rdy, tch);
            tests_run++;
            if (rd !== erd || er !== eer || lat != elat || rdy !== 1'b1 || tch !== !eer) begin
                tests_failed++;
                $display("FAIL rand%0d op%0d @%h: rd=%h err=%b lat=%0d ready=%b touched=%b expected rd=%h err=%b lat=%0d ready=1 touched=%b",
                         n, op, addr, rd, er, lat, rdy, tch, erd, eer, elat, !eer);
            end
        end
    endtask

    task automatic test_final_memory;
        for (int i = 0; i < 64; i++) begin
            tests_run++;
            if (dmem[i] !== ref_word(4 * i)) begin
                tests_failed++;
                $display("FAIL mem_word_%0d: got %h expected %h", i, dmem[i], ref_word(4 * i));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_addr  = '0;
        req_wdata = '0;
        req_rt    = '0;
        for (int i = 0; i < 256; i++) refm[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) dmem[i] = ref_word(4 * i);
        #12;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_mid_write();
        test_lwlr();
        test_back_to_back_random();
        test_final_memory();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
